// File: rtl/booth_pkg.sv
// Shared constants and types for the Booth multiplier accumulator slice.
// The tag struct carries the per-beat sideband alongside the multiplier.
package booth_pkg;

  localparam int BOOTH_WIDTH   = 8;
  localparam int BOOTH_LATENCY = 6;

  typedef enum logic [1:0] {
    SIGN_UU = 2'b00,
    SIGN_US = 2'b01,
    SIGN_SU = 2'b10,
    SIGN_SS = 2'b11
  } sign_mode_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] sign;
    logic       last;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/booth_tag_pipe.sv
// Sideband shift register matched to the multiplier latency, plus a running
// count of group-closing beats currently inside the pipe.
module booth_tag_pipe
  import booth_pkg::*;
#(
  parameter int LATENCY = BOOTH_LATENCY,
  parameter int CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  tag_t             i_tag,
  output tag_t             o_tag,
  output logic [CNT_W-1:0] o_lastsInFlight
);

  tag_t             r_pipe [LATENCY];
  logic [CNT_W-1:0] r_lastsInFlight;
  logic             w_inc;
  logic             w_dec;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag = r_pipe[LATENCY-1];
  assign w_inc = i_tag.valid & i_tag.last;
  assign w_dec = o_tag.valid & o_tag.last;

  // Entry and exit of a last beat on the same edge leave the count unchanged.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lastsInFlight <= '0;
    end else if (w_inc && !w_dec) begin
      r_lastsInFlight <= r_lastsInFlight + CNT_W'(1);
    end else if (!w_inc && w_dec) begin
      r_lastsInFlight <= r_lastsInFlight - CNT_W'(1);
    end
  end

  assign o_lastsInFlight = r_lastsInFlight;

endmodule

// File: rtl/booth_mac_accum8.sv
// Accumulates multiplier products per operand group and queues one result per
// group; issue_ready grants credit so results in flight always fit the FIFO.
module booth_mac_accum8
  import booth_pkg::*;
#(
  parameter int WIDTH      = BOOTH_WIDTH,
  parameter int LATENCY    = BOOTH_LATENCY,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_issue_valid,
  input  logic [1:0]           i_issue_sign,
  input  logic                 i_issue_last,
  output logic                 o_issue_ready,
  input  logic                 i_prod_valid,
  input  logic [2*WIDTH-1:0]   i_prod_data,
  output logic                 o_res_valid,
  output logic [ACC_W-1:0]     o_res_data,
  output logic [15:0]          o_res_count,
  input  logic                 i_res_ready,
  output logic                 o_err_align,
  output logic                 o_err_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(LATENCY + 1);
  localparam int CW = ((LW > AW + 1) ? LW : AW + 1) + 1;

  tag_t            w_issueTag;
  tag_t            w_outTag;
  logic [LW-1:0]   w_lastsInFlight;
  logic            w_accept;
  logic            w_misalign;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] w_sum;
  logic [15:0]     w_beats;

  logic [ACC_W-1:0] r_acc;
  logic [15:0]      r_count;
  logic             r_first;
  logic             r_errAlign;
  logic             r_errOverflow;

  logic [ACC_W-1:0] r_fifoSum [FIFO_DEPTH];
  logic [15:0]      r_fifoCnt [FIFO_DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [AW:0]      w_fifoCount;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_pushReq;
  logic             w_push;
  logic             w_overflow;
  logic [CW-1:0]    w_credit;

  assign w_issueTag = '{valid: i_issue_valid, sign: i_issue_sign, last: i_issue_last};

  booth_tag_pipe #(
    .LATENCY (LATENCY),
    .CNT_W   (LW)
  ) u_tagPipe (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_tag           (w_issueTag),
    .o_tag           (w_outTag),
    .o_lastsInFlight (w_lastsInFlight)
  );

  assign w_accept   = w_outTag.valid & i_prod_valid;
  assign w_misalign = w_outTag.valid ^ i_prod_valid;

  always_comb begin
    w_ext = ACC_W'(i_prod_data);
    if (w_outTag.sign != SIGN_UU) w_ext = ACC_W'($signed(i_prod_data));
  end

  assign w_sum   = (r_first ? '0 : r_acc) + w_ext;
  assign w_beats = r_first ? 16'd1 : satInc16(r_count);

  // A last beat restarts the group even when its result is dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_first <= 1'b1;
    end else if (w_accept) begin
      if (w_outTag.last) begin
        r_first <= 1'b1;
      end else begin
        r_acc   <= w_sum;
        r_count <= w_beats;
        r_first <= 1'b0;
      end
    end
  end

  assign w_fifoCount = r_wrPtr - r_rdPtr;
  assign w_empty     = (w_fifoCount == '0);
  assign w_full      = (w_fifoCount == (AW+1)'(FIFO_DEPTH));
  assign w_pop       = ~w_empty & i_res_ready;
  assign w_pushReq   = w_accept & w_outTag.last;
  assign w_push      = w_pushReq & (~w_full | w_pop);
  assign w_overflow  = w_pushReq & w_full & ~w_pop;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifoSum[r_wrPtr[AW-1:0]] <= w_sum;
      r_fifoCnt[r_wrPtr[AW-1:0]] <= w_beats;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_errAlign    <= 1'b0;
      r_errOverflow <= 1'b0;
    end else begin
      if (w_misalign) r_errAlign    <= 1'b1;
      if (w_overflow) r_errOverflow <= 1'b1;
    end
  end

  assign w_credit      = CW'(w_lastsInFlight) + CW'(w_fifoCount);
  assign o_issue_ready = (w_credit < CW'(FIFO_DEPTH));

  assign o_res_valid    = ~w_empty;
  assign o_res_data     = w_empty ? '0 : r_fifoSum[r_rdPtr[AW-1:0]];
  assign o_res_count    = w_empty ? '0 : r_fifoCnt[r_rdPtr[AW-1:0]];
  assign o_err_align    = r_errAlign;
  assign o_err_overflow = r_errOverflow;

endmodule

// File: tb/tb_booth_mac_accum8.sv
// Directed bench for booth_mac_accum8 with a latency-6 multiplier model and a
// group-level scoreboard of expected results.
module tb_booth_mac_accum8;
  import booth_pkg::*;

  localparam int LAT = 6;

  typedef struct {
    logic [31:0] sum;
    logic [15:0] cnt;
  } exp_t;

  logic        clock = 1'b0;
  logic        rstN;
  logic        issueValid;
  logic [1:0]  issueSign;
  logic        issueLast;
  logic [7:0]  opA;
  logic [7:0]  opB;
  logic        ghostBeat;
  logic        injectValid;
  logic [15:0] injectData;
  logic        resReady;
  logic        issueReady;
  logic        prodValid;
  logic [15:0] prodData;
  logic        resValid;
  logic [31:0] resData;
  logic [15:0] resCount;
  logic        errAlign;
  logic        errOverflow;

  logic        multV [LAT];
  logic [15:0] multD [LAT];

  exp_t        expQ [$];
  logic [31:0] modelAcc;
  logic [15:0] modelCnt;
  logic        modelFirst;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clock = ~clock;

  booth_mac_accum8 dut (
    .i_clk          (clock),
    .i_rst_n        (rstN),
    .i_issue_valid  (issueValid),
    .i_issue_sign   (issueSign),
    .i_issue_last   (issueLast),
    .o_issue_ready  (issueReady),
    .i_prod_valid   (prodValid),
    .i_prod_data    (prodData),
    .o_res_valid    (resValid),
    .o_res_data     (resData),
    .o_res_count    (resCount),
    .i_res_ready    (resReady),
    .o_err_align    (errAlign),
    .o_err_overflow (errOverflow)
  );

  function automatic logic [15:0] mulModel(input logic [1:0] s, input logic [7:0] a,
                                           input logic [7:0] b);
    logic signed [9:0]  sa;
    logic signed [9:0]  sb;
    logic signed [19:0] pr;
    sa = s[1] ? {{2{a[7]}}, a} : {2'b00, a};
    sb = s[0] ? {{2{b[7]}}, b} : {2'b00, b};
    pr = sa * sb;
    return pr[15:0];
  endfunction

  function automatic logic [31:0] extModel(input logic [1:0] s, input logic [15:0] p);
    return (s == 2'b00) ? {16'h0000, p} : {{16{p[15]}}, p};
  endfunction

  // Multiplier stand-in: a fixed six-stage delay of the computed product.
  always @(posedge clock) begin
    multV[0] <= issueValid & ~ghostBeat;
    multD[0] <= mulModel(issueSign, opA, opB);
    for (int i = 1; i < LAT; i++) begin
      multV[i] <= multV[i-1];
      multD[i] <= multD[i-1];
    end
  end

  assign prodValid = multV[LAT-1] | injectValid;
  assign prodData  = injectValid ? injectData : multD[LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    assertCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, expv, expv, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drives one issue cycle and folds the beat into the group-level model.
  task automatic applyStimulus(input logic [1:0] s, input logic last, input logic [7:0] a,
                               input logic [7:0] b, input logic drop = 1'b0,
                               input logic ghost = 1'b0);
    logic [31:0] sum;
    logic [15:0] cnt;
    issueValid = 1'b1;
    issueSign  = s;
    issueLast  = last;
    opA        = a;
    opB        = b;
    ghostBeat  = ghost;
    if (!ghost) begin
      sum = (modelFirst ? 32'd0 : modelAcc) + extModel(s, mulModel(s, a, b));
      cnt = modelFirst ? 16'd1 : modelCnt + 16'd1;
      if (last) begin
        if (!drop) expQ.push_back('{sum: sum, cnt: cnt});
        modelFirst = 1'b1;
      end else begin
        modelAcc   = sum;
        modelCnt   = cnt;
        modelFirst = 1'b0;
      end
    end
    tick();
    issueValid = 1'b0;
    issueLast  = 1'b0;
    ghostBeat  = 1'b0;
  endtask

  task automatic pulseReset();
    rstN = 1'b0;
    modelFirst = 1'b1;
    modelAcc   = '0;
    modelCnt   = '0;
    expQ.delete();
    tick();
    rstN = 1'b1;
  endtask

  task automatic waitValid(input string name);
    for (int i = 0; i < 20 && !resValid; i++) tick();
    checkOutput(name, {31'd0, resValid}, 32'd1);
  endtask

  task automatic drainFifo(input string name);
    resReady = 1'b1;
    for (int i = 0; i < 16 && resValid; i++) tick();
    resReady = 1'b0;
    checkOutput(name, {31'd0, resValid}, 32'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "ResValid"}, {31'd0, resValid}, 32'd0);
    checkOutput({tag, "ResData"}, resData, 32'd0);
    checkOutput({tag, "ResCount"}, {16'd0, resCount}, 32'd0);
    checkOutput({tag, "ErrAlign"}, {31'd0, errAlign}, 32'd0);
    checkOutput({tag, "ErrOverflow"}, {31'd0, errOverflow}, 32'd0);
    checkOutput({tag, "IssueReady"}, {31'd0, issueReady}, 32'd1);
  endtask

  // Every accepted pop is compared against the oldest expected group result.
  always @(negedge clock) begin
    if (rstN && resValid && resReady) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedResult", 32'd1, 32'd0);
      end else begin
        checkOutput("popData", resData, expQ[0].sum);
        checkOutput("popCount", {16'd0, resCount}, {16'd0, expQ[0].cnt});
        void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN        = 1'b0;
    issueValid  = 1'b0;
    issueSign   = 2'b00;
    issueLast   = 1'b0;
    opA         = '0;
    opB         = '0;
    ghostBeat   = 1'b0;
    injectValid = 1'b0;
    injectData  = '0;
    resReady    = 1'b0;
    modelFirst  = 1'b1;
    modelAcc    = '0;
    modelCnt    = '0;
    tick(8);
    checkResetState("reset");
    rstN = 1'b1;
    tick();

    $display("[TB] T1 unsigned 3*4 single-beat group");
    applyStimulus(SIGN_UU, 1'b1, 8'd3, 8'd4);
    tick(5);
    checkOutput("t1EarlyValid", {31'd0, resValid}, 32'd0);
    tick();
    checkOutput("t1ValidAt7", {31'd0, resValid}, 32'd1);
    checkOutput("t1Data", resData, 32'd12);
    checkOutput("t1Count", {16'd0, resCount}, 32'd1);
    drainFifo("t1Drain");

    $display("[TB] T2 signed beats");
    applyStimulus(SIGN_SS, 1'b0, 8'h80, 8'h80);
    applyStimulus(SIGN_SS, 1'b1, 8'hFF, 8'h01);
    waitValid("t2Timeout");
    checkOutput("t2Data", resData, 32'd16383);
    checkOutput("t2Count", {16'd0, resCount}, 32'd2);
    drainFifo("t2Drain");

    $display("[TB] T3 unsigned 255*255 twice");
    applyStimulus(SIGN_UU, 1'b0, 8'hFF, 8'hFF);
    applyStimulus(SIGN_UU, 1'b1, 8'hFF, 8'hFF);
    waitValid("t3Timeout");
    checkOutput("t3Data", resData, 32'd130050);
    checkOutput("t3Count", {16'd0, resCount}, 32'd2);
    drainFifo("t3Drain");

    $display("[TB] T4 credit backpressure");
    applyStimulus(SIGN_UU, 1'b1, 8'd3, 8'd5);
    checkOutput("t4ReadyAfterFirst", {31'd0, issueReady}, 32'd1);
    applyStimulus(SIGN_UU, 1'b1, 8'd7, 8'd2);
    checkOutput("t4ReadyAfterSecond", {31'd0, issueReady}, 32'd0);
    tick(7);
    checkOutput("t4Head", resData, 32'd15);
    checkOutput("t4ReadyFull", {31'd0, issueReady}, 32'd0);
    resReady = 1'b1;
    tick();
    resReady = 1'b0;
    checkOutput("t4ReadyAfterPop", {31'd0, issueReady}, 32'd1);
    checkOutput("t4SecondHead", resData, 32'd14);
    applyStimulus(SIGN_UU, 1'b1, 8'd9, 8'd9);
    tick(8);
    drainFifo("t4Drain");
    checkOutput("t4NoOverflow", {31'd0, errOverflow}, 32'd0);

    $display("[TB] T7 tag without product");
    applyStimulus(SIGN_UU, 1'b1, 8'd4, 8'd4, 1'b0, 1'b1);
    tick(7);
    checkOutput("t7ErrAlign", {31'd0, errAlign}, 32'd1);
    checkOutput("t7NoResult", {31'd0, resValid}, 32'd0);
    pulseReset();
    checkOutput("t7ErrCleared", {31'd0, errAlign}, 32'd0);

    $display("[TB] T5 product without tag mid-group");
    applyStimulus(SIGN_UU, 1'b0, 8'd10, 8'd10);
    tick(7);
    injectValid = 1'b1;
    injectData  = 16'h1234;
    tick();
    injectValid = 1'b0;
    checkOutput("t5ErrAlign", {31'd0, errAlign}, 32'd1);
    applyStimulus(SIGN_UU, 1'b1, 8'd1, 8'd1);
    waitValid("t5Timeout");
    checkOutput("t5Data", resData, 32'd101);
    checkOutput("t5Count", {16'd0, resCount}, 32'd2);
    tick(2);
    checkOutput("t5ErrSticky", {31'd0, errAlign}, 32'd1);
    drainFifo("t5Drain");

    $display("[TB] overflow when issuing past credit");
    applyStimulus(SIGN_UU, 1'b1, 8'd1, 8'd1);
    applyStimulus(SIGN_UU, 1'b1, 8'd2, 8'd2);
    applyStimulus(SIGN_UU, 1'b1, 8'd3, 8'd3, 1'b1);
    tick(8);
    checkOutput("ovfFlag", {31'd0, errOverflow}, 32'd1);
    checkOutput("ovfHead", resData, 32'd1);
    checkOutput("ovfReady", {31'd0, issueReady}, 32'd0);
    drainFifo("ovfDrain");

    $display("[TB] T6 reset mid-group");
    applyStimulus(SIGN_UU, 1'b0, 8'd10, 8'd10);
    tick(2);
    pulseReset();
    checkResetState("t6");
    tick(4);
    checkOutput("t6InFlightAlign", {31'd0, errAlign}, 32'd1);
    applyStimulus(SIGN_UU, 1'b1, 8'd5, 8'd6);
    waitValid("t6Timeout");
    checkOutput("t6Data", resData, 32'd30);
    checkOutput("t6Count", {16'd0, resCount}, 32'd1);
    drainFifo("t6Drain");

    checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
